// File: rtl/motoro3_pkg.sv
//------------------------------------------------------------------------------
// motoro3_pkg -- shared sequencer encodings and the modulo-12 step helper.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package motoro3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_LAST = 2'd3
    } m3_state_t;

    localparam logic [3:0] SG_STEP_IDLE  = 4'd15;
    localparam logic [3:0] SG_STEP_NUM   = 4'd12;
    localparam logic [3:0] SG_HALF_END_A = 4'd5;
    localparam logic [3:0] SG_HALF_END_B = 4'd11;

    // Explicit wrap so the index never visits 12..14.
    function automatic logic [3:0] sg_step_next(input logic [3:0] step, input logic rev);
        if (rev)
            return (step == 4'd0) ? SG_STEP_NUM - 4'd1 : step - 4'd1;
        else
            return (step >= SG_STEP_NUM - 4'd1) ? 4'd0 : step + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motoro3_step_timer.sv
//------------------------------------------------------------------------------
// motoro3_step_timer -- loadable per-step down-counter with First/Last decode.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module motoro3_step_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             active_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             first2_o,
    output logic             first1_o,
    output logic             last2_o,
    output logic             last1_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = loadVal_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // period_i is never below 4 while active, so all four decodes are distinct.
    assign cnt_o    = cnt_q;
    assign first2_o = active_i && (cnt_q == period_i - CNT_W'(1));
    assign first1_o = active_i && (cnt_q == period_i - CNT_W'(2));
    assign last2_o  = active_i && (cnt_q == CNT_W'(1));
    assign last1_o  = active_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/motoro3_step_sequencer.sv
//------------------------------------------------------------------------------
// motoro3_step_sequencer -- 12-substep commutation timebase shared by the phase PWMs.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module motoro3_step_sequencer
    import motoro3_pkg::*;
#(
    parameter int CNT_W      = 25,
    parameter int PERIOD_MIN = 4,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3r_runEn,
    input  logic             m3r_stopReq,
    input  logic             m3r_dirRev,
    input  logic [3:0]       m3r_startStep,
    input  logic [CNT_W-1:0] m3r_stepPeriod,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic             pwmActive1,
    output logic             pwmLastStep1,
    output logic             cycDone,
    output logic [CYC_W-1:0] cycCnt
);

    m3_state_t        state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             cycDone_q, cycDone_d;
    logic             tmrLoad, tmrClear;

    logic [CNT_W-1:0] periodEff;
    logic [3:0]       startStep;
    logic [3:0]       stepNext;
    logic             stepWrap;

    assign periodEff = (m3r_stepPeriod < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : m3r_stepPeriod;
    assign startStep = (m3r_startStep >= SG_STEP_NUM) ? 4'd0 : m3r_startStep;
    assign stepNext  = sg_step_next(step_q, m3r_dirRev);
    assign stepWrap  = m3r_dirRev ? (step_q == 4'd0) : (step_q == SG_STEP_NUM - 4'd1);

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            step_q    <= SG_STEP_IDLE;
            period_q  <= CNT_W'(PERIOD_MIN);
            cyc_q     <= '0;
            cycDone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            period_q  <= period_d;
            cyc_q     <= cyc_d;
            cycDone_q <= cycDone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        period_d  = period_q;
        cyc_d     = cyc_q;
        cycDone_d = 1'b0;
        tmrLoad   = 1'b0;
        tmrClear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m3r_runEn && !m3r_stopReq)
                    state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!m3r_runEn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_RUN;
                    step_d   = startStep;
                    period_d = periodEff;
                    cyc_d    = '0;
                    tmrLoad  = 1'b1;
                end
            end
            ST_RUN, ST_LAST: begin
                // Abort wins over everything, including a pending Last1 boundary.
                if (!m3r_runEn || (m3cntLast1 && state_q == ST_LAST)) begin
                    state_d  = ST_IDLE;
                    step_d   = SG_STEP_IDLE;
                    cyc_d    = '0;
                    tmrClear = 1'b1;
                end else if (m3cntLast1) begin
                    step_d   = stepNext;
                    period_d = periodEff;
                    tmrLoad  = 1'b1;
                    if (stepWrap) begin
                        cycDone_d = 1'b1;
                        cyc_d     = cyc_q + CYC_W'(1);
                    end
                    if (m3r_stopReq && (stepNext == SG_HALF_END_A || stepNext == SG_HALF_END_B))
                        state_d = ST_LAST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pwmActive1   = (state_q == ST_RUN) || (state_q == ST_LAST);
        pwmLastStep1 = (state_q == ST_LAST);
    end

    motoro3_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .nRst      (nRst),
        .clear_i   (tmrClear),
        .load_i    (tmrLoad),
        .loadVal_i (periodEff - CNT_W'(1)),
        .period_i  (period_q),
        .active_i  (pwmActive1),
        .cnt_o     (m3cnt),
        .first2_o  (m3cntFirst2),
        .first1_o  (m3cntFirst1),
        .last2_o   (m3cntLast2),
        .last1_o   (m3cntLast1)
    );

    assign sgStep  = step_q;
    assign cycDone = cycDone_q;
    assign cycCnt  = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_motoro3_step_sequencer.sv
//------------------------------------------------------------------------------
// tb_motoro3_step_sequencer -- scoreboard bench: expected step records vs observed.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_motoro3_step_sequencer;

    localparam int CNT_W = 25;
    localparam int CYC_W = 16;

    logic             clk;
    logic             nRst;
    logic             m3r_runEn;
    logic             m3r_stopReq;
    logic             m3r_dirRev;
    logic [3:0]       m3r_startStep;
    logic [CNT_W-1:0] m3r_stepPeriod;
    logic [3:0]       sgStep;
    logic [CNT_W-1:0] m3cnt;
    logic             m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
    logic             pwmActive1, pwmLastStep1, cycDone;
    logic [CYC_W-1:0] cycCnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  step;
        logic        last;
        logic [7:0]  len;
        logic [7:0]  firstCnt;
        logic [7:0]  f1;
        logic [7:0]  l2;
        logic [7:0]  l1;
        logic [3:0]  nStrClk;
        logic [3:0]  nStrTot;
        logic [7:0]  nAct;
        logic [1:0]  nDone;
        logic [15:0] cyc;
    } rec_t;

    rec_t expQ[$];
    rec_t obsQ[$];

    motoro3_step_sequencer #(
        .CNT_W      (CNT_W),
        .PERIOD_MIN (4),
        .CYC_W      (CYC_W)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .m3r_runEn      (m3r_runEn),
        .m3r_stopReq    (m3r_stopReq),
        .m3r_dirRev     (m3r_dirRev),
        .m3r_startStep  (m3r_startStep),
        .m3r_stepPeriod (m3r_stepPeriod),
        .sgStep         (sgStep),
        .m3cnt          (m3cnt),
        .m3cntFirst2    (m3cntFirst2),
        .m3cntFirst1    (m3cntFirst1),
        .m3cntLast2     (m3cntLast2),
        .m3cntLast1     (m3cntLast1),
        .pwmActive1     (pwmActive1),
        .pwmLastStep1   (pwmLastStep1),
        .cycDone        (cycDone),
        .cycCnt         (cycCnt)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Expected record of one complete step lasting 'period' clocks.
    function automatic rec_t mk(input int step, input int period, input bit last,
                                input int nDone, input int cyc);
        rec_t e;
        e.step     = 4'(step);
        e.last     = last;
        e.len      = 8'(period);
        e.firstCnt = 8'(period - 1);
        e.f1       = 8'd1;
        e.l2       = 8'(period - 2);
        e.l1       = 8'(period - 1);
        e.nStrClk  = 4'd4;
        e.nStrTot  = 4'd4;
        e.nAct     = 8'(period);
        e.nDone    = 2'(nDone);
        e.cyc      = 16'(cyc);
        return e;
    endfunction

    // Collects complete steps (First2 .. Last1) into obsQ; no judging here.
    task automatic observe(input int n, input int budget, output int got, output int firstIdx);
        rec_t r;
        bit   open;
        int   s;
        got = 0; open = 0; firstIdx = -1; r = '0;
        for (int k = 1; k <= budget && got < n; k++) begin
            @(posedge clk);
            if (m3cntFirst2 && !open) begin
                open = 1; r = '0;
                r.step = sgStep; r.last = pwmLastStep1; r.firstCnt = m3cnt[7:0];
                r.f1 = 8'hFF; r.l2 = 8'hFF; r.l1 = 8'hFF;
                if (firstIdx < 0) firstIdx = k;
            end
            if (open) begin
                s = int'(m3cntFirst2) + int'(m3cntFirst1) + int'(m3cntLast2) + int'(m3cntLast1);
                if (m3cntFirst1) r.f1 = r.len;
                if (m3cntLast2)  r.l2 = r.len;
                if (m3cntLast1)  r.l1 = r.len;
                if (s != 0)      r.nStrClk = r.nStrClk + 4'd1;
                r.nStrTot = r.nStrTot + 4'(s);
                if (pwmActive1)  r.nAct  = r.nAct + 8'd1;
                if (cycDone)     r.nDone = r.nDone + 2'd1;
                r.len = r.len + 8'd1;
                if (m3cntLast1) begin
                    r.cyc = cycCnt;
                    obsQ.push_back(r);
                    got++;
                    open = 0;
                end
            end
        end
    endtask

    task automatic go_idle();
        m3r_runEn = 1'b0; m3r_stopReq = 1'b0;
        repeat (3) @(posedge clk);
        expQ.delete(); obsQ.delete();
    endtask

    task automatic start_run(input int period, input int start, input bit rev);
        @(posedge clk);
        m3r_stepPeriod = CNT_W'(period);
        m3r_startStep  = 4'(start);
        m3r_dirRev     = rev;
        m3r_runEn      = 1'b1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; m3r_runEn = 1'b0; m3r_stopReq = 1'b0; m3r_dirRev = 1'b0;
        m3r_startStep = 4'd0; m3r_stepPeriod = CNT_W'(10);
        repeat (2) @(posedge clk);
        checks++;
        if (sgStep !== 4'd15) begin errors++; $display("FAIL reset_sgStep act=%0d req=15", sgStep); end
        checks++;
        if (m3cnt !== '0 || cycCnt !== '0) begin
            errors++; $display("FAIL reset_counts m3cnt=%0d cycCnt=%0d req=0/0", m3cnt, cycCnt);
        end
        checks++;
        if ({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, pwmActive1, pwmLastStep1, cycDone} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags act=%b req=0000000",
                     {m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, pwmActive1, pwmLastStep1, cycDone});
        end
        nRst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_start();
        int got, fi;
        rec_t e, o;
        start_run(10, 0, 1'b0);
        for (int i = 0; i < 3; i++) expQ.push_back(mk(i, 10, 1'b0, 0, 0));
        observe(3, 60, got, fi);
        checks++;
        if (got !== 3) begin errors++; $display("FAIL start_count act=%0d req=3", got); end
        checks++;
        if (fi !== 2) begin errors++; $display("FAIL start_latency act=%0d req=2", fi); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL start_step act=%h req=%h", o, e); end
        end
        go_idle();
    endtask

    task automatic test_clamp();
        int got, fi;
        rec_t e, o;
        start_run(2, 13, 1'b0);
        expQ.push_back(mk(0, 4, 1'b0, 0, 0));
        expQ.push_back(mk(1, 4, 1'b0, 0, 0));
        observe(2, 30, got, fi);
        checks++;
        if (got !== 2) begin errors++; $display("FAIL clamp2_count act=%0d req=2", got); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL clamp2_step act=%h req=%h", o, e); end
        end
        go_idle();
        start_run(0, 4, 1'b0);
        expQ.push_back(mk(4, 4, 1'b0, 0, 0));
        expQ.push_back(mk(5, 4, 1'b0, 0, 0));
        observe(2, 30, got, fi);
        checks++;
        if (got !== 2) begin errors++; $display("FAIL clamp0_count act=%0d req=2", got); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL clamp0_step act=%h req=%h", o, e); end
        end
        go_idle();
    endtask

    task automatic test_stop();
        int got, fi;
        rec_t e, o;
        start_run(4, 7, 1'b0);
        repeat (2) @(posedge clk);
        m3r_stopReq = 1'b1;
        for (int s = 8; s <= 11; s++) expQ.push_back(mk(s, 4, s == 11, 0, 0));
        observe(4, 40, got, fi);
        checks++;
        if (got !== 4) begin errors++; $display("FAIL stop_count act=%0d req=4", got); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stop_step act=%h req=%h", o, e); end
        end
        @(posedge clk);
        checks++;
        if (sgStep !== 4'd15 || pwmActive1 !== 1'b0) begin
            errors++; $display("FAIL stop_idle sgStep=%0d act=%b req=15/0", sgStep, pwmActive1);
        end
        repeat (4) @(posedge clk);
        checks++;
        if (sgStep !== 4'd15 || pwmActive1 !== 1'b0) begin
            errors++; $display("FAIL stop_hold sgStep=%0d act=%b req=15/0", sgStep, pwmActive1);
        end
        go_idle();
    endtask

    task automatic test_reverse_wrap();
        int got, fi;
        rec_t e, o;
        start_run(6, 1, 1'b1);
        expQ.push_back(mk(1, 6, 1'b0, 0, 0));
        expQ.push_back(mk(0, 6, 1'b0, 0, 0));
        expQ.push_back(mk(11, 6, 1'b0, 1, 1));
        expQ.push_back(mk(10, 6, 1'b0, 0, 1));
        observe(4, 50, got, fi);
        checks++;
        if (got !== 4) begin errors++; $display("FAIL rev_count act=%0d req=4", got); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rev_step act=%h req=%h", o, e); end
        end
        go_idle();
    endtask

    task automatic test_period_change();
        int got, fi, n;
        bit found;
        rec_t e, o;
        start_run(20, 0, 1'b0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            if (pwmActive1 && m3cnt == CNT_W'(12)) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL pchg_reach act=0 req=1"); end
        m3r_stepPeriod = CNT_W'(8);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            if (m3cntLast1) break;
        end
        checks++;
        if (n !== 12) begin errors++; $display("FAIL pchg_remaining act=%0d req=12", n); end
        expQ.push_back(mk(1, 8, 1'b0, 0, 0));
        expQ.push_back(mk(2, 8, 1'b0, 0, 0));
        observe(2, 30, got, fi);
        checks++;
        if (got !== 2) begin errors++; $display("FAIL pchg_count act=%0d req=2", got); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL pchg_step act=%h req=%h", o, e); end
        end
        go_idle();
    endtask

    task automatic test_abort();
        bit found;
        start_run(10, 2, 1'b0);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk);
            if (pwmActive1 && m3cnt == CNT_W'(5)) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach act=0 req=1"); end
        m3r_runEn = 1'b0;
        @(posedge clk);
        checks++;
        if (sgStep !== 4'd15 || m3cnt !== '0 ||
            {pwmActive1, pwmLastStep1, m3cntLast2, m3cntLast1} !== 4'b0) begin
            errors++;
            $display("FAIL abort_idle sgStep=%0d m3cnt=%0d flags=%b req=15/0/0000", sgStep, m3cnt,
                     {pwmActive1, pwmLastStep1, m3cntLast2, m3cntLast1});
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        int got, fi;
        rec_t e, o;
        start_run(4, 3, 1'b0);
        repeat (5) @(posedge clk);
        #10 nRst = 1'b0;
        #1;
        checks++;
        if (sgStep !== 4'd15 || m3cnt !== '0 || cycCnt !== '0) begin
            errors++; $display("FAIL areset_state sgStep=%0d m3cnt=%0d cyc=%0d req=15/0/0", sgStep, m3cnt, cycCnt);
        end
        checks++;
        if ({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, pwmActive1, pwmLastStep1, cycDone} !== 7'b0) begin
            errors++;
            $display("FAIL areset_flags act=%b req=0000000",
                     {m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, pwmActive1, pwmLastStep1, cycDone});
        end
        @(posedge clk);
        m3r_startStep = 4'd0;
        nRst = 1'b1;
        expQ.push_back(mk(0, 4, 1'b0, 0, 0));
        expQ.push_back(mk(1, 4, 1'b0, 0, 0));
        observe(2, 30, got, fi);
        checks++;
        if (got !== 2 || fi !== 2) begin
            errors++; $display("FAIL areset_restart count=%0d latency=%0d req=2/2", got, fi);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL areset_step act=%h req=%h", o, e); end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_start();
        test_clamp();
        test_stop();
        test_reverse_wrap();
        test_period_change();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
